// File: rtl/clock_setting_controller_if.sv
// Control bundle between the clock-setting controller and its buttons, tick source and counter chain.
// The pb_right_level signal exists only when CLOCK_SETTING_AUTOREPEAT_EN is defined.
interface clock_setting_if;
   logic       setting_mode;
   logic       pb_left_pu;
   logic       pb_right_pu;
   logic       tick_1hz;
`ifdef CLOCK_SETTING_AUTOREPEAT_EN
   logic       pb_right_level;
`endif
   logic [5:0] field_inc;
   logic [2:0] field_sel;
   logic       sec_clear;
   logic       blink;
   logic       timeout_flag;

   modport master (
      output setting_mode, pb_left_pu, pb_right_pu, tick_1hz,
`ifdef CLOCK_SETTING_AUTOREPEAT_EN
      output pb_right_level,
`endif
      input  field_inc, field_sel, sec_clear, blink, timeout_flag
   );

   modport slave (
      input  setting_mode, pb_left_pu, pb_right_pu, tick_1hz,
`ifdef CLOCK_SETTING_AUTOREPEAT_EN
      input  pb_right_level,
`endif
      output field_inc, field_sel, sec_clear, blink, timeout_flag
   );
endinterface

// File: rtl/clock_setting_controller.sv
// Run/setting sequencer for the BCD clock counter chain: tick forwarding, field cursor, blink, idle timeout.
// Optional held-button auto-repeat is enabled by defining CLOCK_SETTING_AUTOREPEAT_EN.
module clock_setting_controller #(
   parameter int TIMEOUT_S = 30
`ifdef CLOCK_SETTING_AUTOREPEAT_EN
   , parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE = 10
`endif
) (
   input  logic           clk,
   input  logic           reset,
   clock_setting_if.slave bus
);
   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_YEAR = 3'd1,
      ST_MON  = 3'd2,
      ST_DAY  = 3'd3,
      ST_HR   = 3'd4,
      ST_MIN  = 3'd5
   } state_t;

   state_t     state_r, state_s;
   logic       mode_d_r;
   logic [5:0] field_inc_r, field_inc_s;
   logic       sec_clear_r, sec_clear_s;
   logic       blink_r, blink_s;
   logic       timeout_flag_r, timeout_flag_s;
   logic [7:0] idle_r, idle_s, idle_inc_s;
   logic       rise_s, fall_s, inc_req_s, activity_s, repeat_fire_s;

   function automatic logic [5:0] field_onehot(input state_t st);
      case (st)
         ST_YEAR: field_onehot = 6'b100000;
         ST_MON:  field_onehot = 6'b010000;
         ST_DAY:  field_onehot = 6'b001000;
         ST_HR:   field_onehot = 6'b000100;
         ST_MIN:  field_onehot = 6'b000010;
         default: field_onehot = 6'b000000;
      endcase
   endfunction

   function automatic state_t next_field(input state_t st);
      case (st)
         ST_YEAR: next_field = ST_MON;
         ST_MON:  next_field = ST_DAY;
         ST_DAY:  next_field = ST_HR;
         ST_HR:   next_field = ST_MIN;
         ST_MIN:  next_field = ST_YEAR;
         default: next_field = ST_YEAR;
      endcase
   endfunction

   assign rise_s     = bus.setting_mode & ~mode_d_r;
   assign fall_s     = ~bus.setting_mode & mode_d_r;
   assign idle_inc_s = (idle_r == 8'hFF) ? idle_r : idle_r + 8'd1;
   assign inc_req_s  = bus.pb_right_pu | repeat_fire_s;
   assign activity_s = bus.pb_left_pu | inc_req_s;

`ifdef CLOCK_SETTING_AUTOREPEAT_EN
   logic [15:0] hold_r, hold_s, rate_r, rate_s;

   // Held-level delay then fixed-rate repeat; restarts on release, cursor move or leaving setting.
   always_comb begin
      hold_s        = 16'd0;
      rate_s        = 16'd0;
      repeat_fire_s = 1'b0;
      if ((state_r != ST_RUN) && bus.pb_right_level && !bus.pb_left_pu && !fall_s) begin
         if (hold_r < 16'(REPEAT_DELAY)) begin
            hold_s = hold_r + 16'd1;
         end else begin
            hold_s        = hold_r;
            repeat_fire_s = (rate_r == 16'd0);
            rate_s        = (rate_r == 16'(REPEAT_RATE - 1)) ? 16'd0 : rate_r + 16'd1;
         end
      end else begin
         hold_s = 16'd0;
      end
   end

   // Auto-repeat counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_r <= 16'd0;
         rate_r <= 16'd0;
      end else begin
         hold_r <= hold_s;
         rate_r <= rate_s;
      end
   end
`else
   assign repeat_fire_s = 1'b0;
`endif

   // Next-state and next-output logic for the run/setting sequencer.
   always_comb begin
      state_s        = state_r;
      field_inc_s    = 6'b000000;
      sec_clear_s    = 1'b0;
      blink_s        = blink_r;
      timeout_flag_s = fall_s ? 1'b0 : timeout_flag_r;
      idle_s         = idle_r;
      case (state_r)
         ST_RUN: begin
            blink_s = 1'b0;
            if (rise_s) begin
               state_s     = ST_YEAR;
               sec_clear_s = 1'b1;
               blink_s     = 1'b1;
               idle_s      = 8'd0;
            end else begin
               field_inc_s = {5'b00000, bus.tick_1hz};
            end
         end
         ST_YEAR, ST_MON, ST_DAY, ST_HR, ST_MIN: begin
            if (fall_s) begin
               state_s = ST_RUN;
               blink_s = 1'b0;
               idle_s  = 8'd0;
            end else if (activity_s) begin
               // Increment targets the field selected before any cursor advance.
               idle_s      = 8'd0;
               field_inc_s = inc_req_s ? field_onehot(state_r) : 6'b000000;
               if (bus.pb_left_pu) begin
                  state_s = next_field(state_r);
                  blink_s = 1'b1;
               end else begin
                  blink_s = bus.tick_1hz ? ~blink_r : blink_r;
               end
            end else if (bus.tick_1hz) begin
               if (idle_inc_s >= 8'(TIMEOUT_S)) begin
                  state_s        = ST_RUN;
                  blink_s        = 1'b0;
                  idle_s         = 8'd0;
                  timeout_flag_s = 1'b1;
               end else begin
                  idle_s  = idle_inc_s;
                  blink_s = ~blink_r;
               end
            end else begin
               idle_s = idle_r;
            end
         end
         default: begin
            state_s = ST_RUN;
            blink_s = 1'b0;
            idle_s  = 8'd0;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_RUN;
         mode_d_r       <= 1'b0;
         field_inc_r    <= 6'b000000;
         sec_clear_r    <= 1'b0;
         blink_r        <= 1'b0;
         timeout_flag_r <= 1'b0;
         idle_r         <= 8'd0;
      end else begin
         state_r        <= state_s;
         mode_d_r       <= bus.setting_mode;
         field_inc_r    <= field_inc_s;
         sec_clear_r    <= sec_clear_s;
         blink_r        <= blink_s;
         timeout_flag_r <= timeout_flag_s;
         idle_r         <= idle_s;
      end
   end

   assign bus.field_inc    = field_inc_r;
   assign bus.field_sel    = state_r;
   assign bus.sec_clear    = sec_clear_r;
   assign bus.blink        = blink_r;
   assign bus.timeout_flag = timeout_flag_r;
endmodule

// File: tb/tb_clock_setting_controller.sv
// Directed plus randomized bench for clock_setting_controller against a field-index reference model.
module tb_clock_setting_controller;
   localparam int TO = 3;

   logic clk;
   logic reset;
   clock_setting_if bus ();

   clock_setting_controller #(.TIMEOUT_S(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: field 0 = run, 1..5 = year..min.
   int         m_field;
   bit         m_prev;
   bit         m_flag;
   int         m_idle;
   bit         m_blink;
   logic [5:0] m_inc;
   bit         m_sc;

   task automatic model_reset();
      m_field = 0; m_prev = 0; m_flag = 0; m_idle = 0; m_blink = 0; m_inc = 6'd0; m_sc = 0;
   endtask

   task automatic model_step(input bit sm, input bit pl, input bit pr, input bit tk);
      bit rise, fall;
      rise = sm && !m_prev;
      fall = !sm && m_prev;
      m_prev = sm;
      m_inc = 6'd0;
      m_sc = 0;
      if (fall) m_flag = 0;
      if (m_field == 0) begin
         m_blink = 0;
         if (rise) begin
            m_field = 1; m_sc = 1; m_blink = 1; m_idle = 0;
         end else if (tk) begin
            m_inc = 6'd1;
         end
      end else if (fall) begin
         m_field = 0; m_blink = 0; m_idle = 0;
      end else if (pl || pr) begin
         m_idle = 0;
         if (pr) m_inc = 6'(1 << (6 - m_field));
         if (pl) begin
            m_field = (m_field % 5) + 1;
            m_blink = 1;
         end else if (tk) begin
            m_blink = !m_blink;
         end
      end else if (tk) begin
         m_idle = (m_idle < 255) ? m_idle + 1 : 255;
         if (m_idle >= TO) begin
            m_field = 0; m_flag = 1; m_blink = 0; m_idle = 0;
         end else begin
            m_blink = !m_blink;
         end
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".field_inc"},    {2'b00, bus.field_inc},          {2'b00, m_inc});
      check({tag, ".field_sel"},    {5'b00000, bus.field_sel},       8'(m_field));
      check({tag, ".sec_clear"},    {7'b0000000, bus.sec_clear},     {7'b0000000, m_sc});
      check({tag, ".blink"},        {7'b0000000, bus.blink},         {7'b0000000, m_blink});
      check({tag, ".timeout_flag"}, {7'b0000000, bus.timeout_flag},  {7'b0000000, m_flag});
      check({tag, ".onehot"},       {7'b0000000, ($countones(bus.field_inc) <= 1)}, 8'd1);
   endtask

   task automatic step(input string tag, input bit sm, input bit pl, input bit pr, input bit tk);
      bus.setting_mode = sm;
      bus.pb_left_pu   = pl;
      bus.pb_right_pu  = pr;
      bus.tick_1hz     = tk;
      model_step(sm, pl, pr, tk);
      @(posedge clk);
      #1;
      bus.pb_left_pu  = 1'b0;
      bus.pb_right_pu = 1'b0;
      bus.tick_1hz    = 1'b0;
      check_all(tag);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".field_inc"},    {2'b00, bus.field_inc},          8'd0);
      check({tag, ".field_sel"},    {5'b00000, bus.field_sel},       8'd0);
      check({tag, ".sec_clear"},    {7'b0000000, bus.sec_clear},     8'd0);
      check({tag, ".blink"},        {7'b0000000, bus.blink},         8'd0);
      check({tag, ".timeout_flag"}, {7'b0000000, bus.timeout_flag},  8'd0);
   endtask

   initial begin
      reset            = 1'b0;
      bus.setting_mode = 1'b0;
      bus.pb_left_pu   = 1'b0;
      bus.pb_right_pu  = 1'b0;
      bus.tick_1hz     = 1'b0;
`ifdef CLOCK_SETTING_AUTOREPEAT_EN
      bus.pb_right_level = 1'b0;
`endif
      model_reset();
      #2;
      check_reset_values("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Run mode: each tick forwarded to seconds one cycle later.
      for (int i = 0; i < 3; i++) begin
         step("run_tick", 1'b0, 1'b0, 1'b0, 1'b1);
         check("run_tick.sec_inc", {2'b00, bus.field_inc}, 8'h01);
         step("run_gap", 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Entry coincident with a tick: tick dropped, seconds cleared.
      step("enter", 1'b1, 1'b0, 1'b0, 1'b1);
      check("enter.no_inc", {2'b00, bus.field_inc}, 8'h00);
      check("enter.sec_clear", {7'b0000000, bus.sec_clear}, 8'h01);
      check("enter.sel_year", {5'b00000, bus.field_sel}, 8'h01);
      step("enter2", 1'b1, 1'b0, 1'b0, 1'b0);
      check("enter2.sec_clear_off", {7'b0000000, bus.sec_clear}, 8'h00);

      // Year increments then cursor advance to month.
      step("yr_inc1", 1'b1, 1'b0, 1'b1, 1'b0);
      check("yr_inc1.val", {2'b00, bus.field_inc}, 8'h20);
      step("yr_inc2", 1'b1, 1'b0, 1'b1, 1'b0);
      check("yr_inc2.val", {2'b00, bus.field_inc}, 8'h20);
      step("yr_left", 1'b1, 1'b1, 1'b0, 1'b0);
      step("mon_inc", 1'b1, 1'b0, 1'b1, 1'b0);
      check("mon_inc.val", {2'b00, bus.field_inc}, 8'h10);
      check("mon_inc.sel", {5'b00000, bus.field_sel}, 8'h02);

      // Walk to minutes, then simultaneous left+right.
      for (int i = 0; i < 3; i++) step("walk", 1'b1, 1'b1, 1'b0, 1'b0);
      step("min_both", 1'b1, 1'b1, 1'b1, 1'b0);
      check("min_both.inc", {2'b00, bus.field_inc}, 8'h02);
      check("min_both.wrap", {5'b00000, bus.field_sel}, 8'h01);

      // Idle timeout after TO ticks; setting_mode still high does not re-enter.
      for (int i = 0; i < TO; i++) step("idle", 1'b1, 1'b0, 1'b0, 1'b1);
      check("timeout.sel", {5'b00000, bus.field_sel}, 8'h00);
      check("timeout.flag", {7'b0000000, bus.timeout_flag}, 8'h01);
      step("post_to_tick", 1'b1, 1'b0, 1'b0, 1'b1);
      check("post_to_tick.fwd", {2'b00, bus.field_inc}, 8'h01);
      step("mode_fall", 1'b0, 1'b0, 1'b0, 1'b0);
      check("mode_fall.flag", {7'b0000000, bus.timeout_flag}, 8'h00);

      // Reset while in hour field with a pending increment.
      step("reenter", 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("to_hr", 1'b1, 1'b1, 1'b0, 1'b0);
      check("to_hr.sel", {5'b00000, bus.field_sel}, 8'h04);
      bus.pb_right_pu = 1'b1;
      reset = 1'b0;
      #1;
      check_reset_values("mid_reset");
      @(posedge clk);
      #1;
      bus.pb_right_pu  = 1'b0;
      bus.setting_mode = 1'b0;
      check_reset_values("mid_reset_held");
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
         check("after_reset.no_inc", {2'b00, bus.field_inc}, 8'h00);
      end

      // Randomized traffic against the model.
      begin
         bit sm;
         sm = 1'b0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) sm = !sm;
            step("rand", sm, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
